// File: rtl/cpu_ctrl_pkg.sv
// Shared run-control definitions: state encodings, HALT opcode, drain default.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W       = 3;
  localparam int unsigned DRAIN_W       = 3;
  localparam int unsigned DRAIN_CYC_DEF = 3;
  localparam int unsigned OPCODE_W      = 6;

  localparam logic [OPCODE_W-1:0] OP_HALT = 6'h3F;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } run_state_e;

  // Decode qualifier used by the ID stage to raise halt_seen.
  function automatic logic is_halt_op(input logic [OPCODE_W-1:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: start/stop/step/HALT handling, pipeline drain, cycle count.
// Optional breakpoint compare enabled by defining RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_step,
  input  logic             halt_seen,
  input  logic [7:0]       pc,
  input  logic [7:0]       bp_addr,
  input  logic             bp_valid,
  output logic             cpu_enable,
  output logic             cpu_start,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  run_state_e         state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               en_q, en_d;
  logic               start_q, start_d;
  logic               halted_q, halted_d;
  logic               clr_cnt_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bp_hit_c;

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic first_run_q;

  // Marks the first RUN cycle so a breakpoint on the resume pc does not re-fire.
  always_ff @(posedge clock) begin
    if (reset) first_run_q <= 1'b0;
    else       first_run_q <= (state_d == S_RUN) && (state_q != S_RUN);
  end

  assign bp_hit_c = bp_valid && (pc == bp_addr) && !first_run_q;
`else
  logic unused_bp_c;
  assign unused_bp_c = ^{pc, bp_addr, bp_valid};
  assign bp_hit_c    = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    start_d   = 1'b0;
    clr_cnt_c = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (cmd_start) begin
          state_d   = S_RUN;
          start_d   = 1'b1;
          clr_cnt_c = 1'b1;
        end else if (cmd_step) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (halt_seen || cmd_stop || bp_hit_c) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYC);
        end
      end
      S_STEP: begin
        state_d = halt_seen ? S_HALT : S_IDLE;
      end
      S_DRAIN: begin
        if (drain_q <= DRAIN_W'(1)) begin
          state_d = S_HALT;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        drain_d = '0;
      end
    endcase
    en_d     = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
    halted_d = (state_d == S_HALT);
  end

  // Executed-cycle counter: cleared on start, saturating increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_c) begin
      cnt_d = '0;
    end else if (en_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, drain counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      drain_q  <= '0;
      en_q     <= 1'b0;
      start_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      en_q     <= en_d;
      start_q  <= start_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_enable = en_q;
  assign cpu_start  = start_q;
  assign state      = 3'(state_q);
  assign halted     = halted_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: behavioural model plus directed literal checks.
module tb_cpu_run_ctrl;

  localparam int unsigned DRAIN_CYC = 3;
  localparam int unsigned CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;
`ifdef RUN_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_start = 1'b0;
  logic             cmd_stop = 1'b0;
  logic             cmd_step = 1'b0;
  logic             halt_seen = 1'b0;
  logic [7:0]       pc = 8'h00;
  logic [7:0]       bp_addr = 8'h00;
  logic             bp_valid = 1'b0;
  logic             cpu_enable;
  logic             cpu_start;
  logic [2:0]       state;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;

  cpu_run_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_step(cmd_step), .halt_seen(halt_seen), .pc(pc), .bp_addr(bp_addr),
    .bp_valid(bp_valid), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
    .state(state), .halted(halted), .cycle_cnt(cycle_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 running, 2 stepping, 3 draining, 4 halted.
  int mode = 0;
  int drain_left = 0;
  int run_cycles = 0;
  int cnt = 0;
  bit start_pulse = 1'b0;

  function automatic bit model_en(input int m);
    return (m == 1) || (m == 2) || (m == 3);
  endfunction

  always @(posedge clock) begin
    int  prev;
    bit  bp;
    if (reset) begin
      mode = 0; drain_left = 0; run_cycles = 0; cnt = 0; start_pulse = 1'b0;
    end else begin
      prev = mode;
      bp = BP_EN && bp_valid && (pc == bp_addr) && (run_cycles > 0);
      if (model_en(prev)) cnt = (cnt < CNT_MAX) ? cnt + 1 : CNT_MAX;
      start_pulse = 1'b0;
      if (prev == 0 || prev == 4) begin
        if (cmd_start) begin mode = 1; start_pulse = 1'b1; cnt = 0; end
        else if (cmd_step) mode = 2;
      end else if (prev == 1) begin
        if (halt_seen || cmd_stop || bp) begin mode = 3; drain_left = DRAIN_CYC; end
      end else if (prev == 2) begin
        mode = halt_seen ? 4 : 0;
      end else if (prev == 3) begin
        drain_left = drain_left - 1;
        if (drain_left == 0) mode = 4;
      end
      run_cycles = (mode == 1 && prev == 1) ? run_cycles + 1 : 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      check("m_state", int'(state), mode);
      check("m_enable", int'(cpu_enable), int'(model_en(mode)));
      check("m_start", int'(cpu_start), int'(start_pulse));
      check("m_halted", int'(halted), int'(mode == 4));
      check("m_cnt", int'(cycle_cnt), cnt);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    chk_on = 1'b1;
    check("rst_state", int'(state), 0);
    check("rst_en", int'(cpu_enable), 0);
    check("rst_start", int'(cpu_start), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_cnt", int'(cycle_cnt), 0);

    // Start and count.
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("t1_state", int'(state), 1);
    check("t1_start", int'(cpu_start), 1);
    check("t1_en", int'(cpu_enable), 1);
    check("t1_cnt0", int'(cycle_cnt), 0);
    tick();
    check("t1_start_off", int'(cpu_start), 0);
    check("t1_cnt1", int'(cycle_cnt), 1);
    tick(2);
    check("t1_cnt3", int'(cycle_cnt), 3);

    // HALT opcode: drain then park.
    halt_seen = 1'b1; tick(); halt_seen = 1'b0;
    check("t2_drain", int'(state), 3);
    tick(2);
    check("t2_still_drain", int'(state), 3);
    check("t2_drain_en", int'(cpu_enable), 1);
    tick();
    check("t2_halt", int'(state), 4);
    check("t2_halted", int'(halted), 1);
    check("t2_en_off", int'(cpu_enable), 0);
    check("t2_cnt", int'(cycle_cnt), 7);
    tick(2);
    check("t2_cnt_frozen", int'(cycle_cnt), 7);

    // Single steps from IDLE.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_step = 1'b1; tick(); cmd_step = 1'b0;
      check("t3_step_en", int'(cpu_enable), 1);
      tick();
      check("t3_step_done", int'(cpu_enable), 0);
    end
    check("t3_idle", int'(state), 0);
    check("t3_cnt", int'(cycle_cnt), 3);
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    halt_seen = 1'b1; tick(); halt_seen = 1'b0;
    check("t3_step_halt", int'(state), 4);
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    check("t3_halt_step", int'(state), 2);
    tick();
    check("t3_cnt_kept", int'(cycle_cnt), 5);

    // Start wins over step; stop+halt together drain once, no re-trigger.
    cmd_start = 1'b1; cmd_step = 1'b1; tick(); cmd_start = 1'b0; cmd_step = 1'b0;
    check("t4_start_wins", int'(state), 1);
    tick(2);
    cmd_stop = 1'b1; halt_seen = 1'b1; tick(); cmd_stop = 1'b0;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0; halt_seen = 1'b0;
    check("t4_no_restart", int'(cpu_start), 0);
    tick();
    check("t4_drain_last", int'(state), 3);
    tick();
    check("t4_halt", int'(state), 4);

    // Counter saturation, then reset during drain.
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    tick(20);
    check("t5_sat", int'(cycle_cnt), 15);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("t5_rst_state", int'(state), 0);
    check("t5_rst_en", int'(cpu_enable), 0);
    check("t5_rst_cnt", int'(cycle_cnt), 0);

    // Breakpoint at pc 0x05.
    pc = 8'h05; bp_addr = 8'h05; bp_valid = 1'b1;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    tick();
    check("t6_first_masked", int'(state), 1);
    pc = 8'h01; tick();
    pc = 8'h05; tick();
    check("t6_bp_hit", int'(state), BP_EN ? 3 : 1);
    pc = 8'h06; tick(3);
    check("t6_bp_park", int'(state), BP_EN ? 4 : 1);
    pc = 8'h05; cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("t6_restart", int'(state), 1);
    tick();
    check("t6_resume_masked", int'(state), 1);
    pc = 8'h07; tick();
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    tick(3);
    check("t6_final_halt", int'(state), 4);
    bp_valid = 1'b0;
    tick();
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
